oam_arbiter: RTL
================

OAM_ARBITER -- requirements
Module: oam_arbiter

Interface
REQ-001 Parameter OAM_ADDR_SIZE, default 6, SHALL set the OAM word address width (64 words of 32 bits).
REQ-002 Parameter CPU_MAX_WAIT, default 8, SHALL set the cycles a pending CPU request may be refused before it is forced through.
REQ-003 Ports SHALL be:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- line_active  in  1  high while the sprite line evaluator owns the priority window
- eval_req  in  1  evaluator requests a read
- eval_addr  in  OAM_ADDR_SIZE  evaluator read address
- eval_gnt  out  1  evaluator read issued this cycle
- eval_valid  out  1  eval_data valid; one cycle after eval_gnt
- eval_data  out  32  OAM word for the evaluator
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  OAM_ADDR_SIZE  CPU address
- cpu_wdata  in  32  CPU write data
- cpu_ack  out  1  CPU access complete
- cpu_rdata  out  32  CPU read data, valid with cpu_ack on reads
- mem_addr  out  OAM_ADDR_SIZE  OAM RAM address
- mem_we  out  1  OAM RAM write enable
- mem_wdata  out  32  OAM RAM write data
- mem_rdata  in  32  OAM RAM read data, 1-cycle synchronous latency

Function
REQ-004 The block SHALL issue at most one RAM access per cycle; mem_addr, mem_we, mem_wdata SHALL be combinational from the same-cycle grant decision.
REQ-005 The FSM SHALL have states IDLE, EVAL, CPU, which record the previous cycle's grant: IDLE = none, EVAL = eval_gnt, CPU = CPU grant.
REQ-006 The CPU SHALL be eligible when cpu_req = 1 and state != CPU, so a held request is not re-granted in its ack cycle.
REQ-007 The grant decision SHALL be:
- only the evaluator requests: evaluator
- only an eligible CPU requests: CPU
- both, line_active = 0: CPU
- both, line_active = 1, wait counter < CPU_MAX_WAIT: evaluator
- both, line_active = 1, wait counter = CPU_MAX_WAIT: CPU
REQ-008 The wait counter SHALL increment when the CPU is eligible and not granted, saturate at CPU_MAX_WAIT, and clear on a CPU grant.
REQ-009 The wait counter SHALL clear when cpu_req = 0.
REQ-010 An evaluator grant SHALL drive mem_addr = eval_addr, mem_we = 0, and eval_gnt = 1 combinationally that cycle.
REQ-011 The evaluator SHALL hold eval_addr while eval_gnt = 0.
REQ-012 eval_valid SHALL be 1 exactly in the cycle after each eval_gnt, with eval_data = mem_rdata; eval_data is don't-care otherwise.
REQ-013 A CPU grant SHALL drive mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata.
REQ-014 cpu_ack SHALL pulse for one cycle, exactly in the cycle after each CPU grant.
REQ-015 On a CPU read, cpu_rdata SHALL equal mem_rdata in the cpu_ack cycle.
REQ-016 When no grant is made, mem_we SHALL be 0, mem_addr SHALL hold its previous value, and mem_wdata SHALL be don't-care.
REQ-017 line_active edges SHALL take effect on the same-cycle decision, with no extra latency.
REQ-018 cpu_req dropping before ack is illegal; behaviour for an already-granted access SHALL still complete with cpu_ack.
REQ-019 Back-to-back evaluator grants SHALL be allowed every cycle, giving full throughput with the CPU idle.
REQ-020 A CPU access SHALL sustain at most one completed access per 2 cycles.

Reset
REQ-021 While reset = 1 the block SHALL hold:
- state = IDLE, wait counter = 0
- eval_gnt = 0, eval_valid = 0
- cpu_ack = 0, mem_we = 0, mem_addr = 0
- eval_data = 0, cpu_rdata = 0
REQ-022 Reset asserted mid-access SHALL cancel any pending eval_valid or cpu_ack. After release, arbitration SHALL restart from IDLE on the next rising edge.

Verification
REQ-023 Evaluator only, eval_req = 1 with addresses 0..63 over 64 cycles -> eval_gnt every cycle; eval_valid from cycle 1 to cycle 64 carrying words 0..63.
REQ-024 line_active = 0, both request, cpu_we = 1, cpu_addr = 5, cpu_wdata = 0xDEADBEEF -> CPU granted first; mem_we = 1 for one cycle; cpu_ack the next cycle; evaluator granted in the ack cycle.
REQ-025 line_active = 1, both request continuously, CPU_MAX_WAIT = 8 -> 8 evaluator grants, then 1 CPU grant, then cpu_ack; the pattern repeats while the CPU re-requests.
REQ-026 CPU read of address 5 after REQ-024 -> cpu_ack with cpu_rdata = 0xDEADBEEF.
REQ-027 CPU holds cpu_req through its ack cycle, no evaluator request -> exactly one mem access and one cpu_ack; no duplicate grant.
REQ-028 Reset pulsed in the cycle after a CPU grant -> no cpu_ack; all outputs 0; a new request after release is granted normally.

Source files
------------

// File: rtl/oam_arbiter.sv
// rtl/oam_arbiter.sv - single-port OAM RAM arbiter between the sprite line evaluator and the CPU
// The CPU is starved for at most CPU_MAX_WAIT refused cycles while line_active gives the evaluator priority.
module oam_arbiter #(
    parameter int OAM_ADDR_SIZE = 6,
    parameter int CPU_MAX_WAIT  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     line_active,
    input  logic                     eval_req,
    input  logic [OAM_ADDR_SIZE-1:0] eval_addr,
    output logic                     eval_gnt,
    output logic                     eval_valid,
    output logic [31:0]              eval_data,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [OAM_ADDR_SIZE-1:0] cpu_addr,
    input  logic [31:0]              cpu_wdata,
    output logic                     cpu_ack,
    output logic [31:0]              cpu_rdata,
    output logic [OAM_ADDR_SIZE-1:0] mem_addr,
    output logic                     mem_we,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    localparam int WW = $clog2(CPU_MAX_WAIT + 1) < 1 ? 1 : $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        CPU  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [WW-1:0]            wait_q, wait_d;
    logic [OAM_ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic                     cpu_rd_q, cpu_rd_d;
    logic                     cpu_elig;
    logic                     gnt_eval;
    logic                     gnt_cpu;

    // A held CPU request is not eligible in its own ack cycle, preventing a duplicate access.
    always_comb begin
        cpu_elig = cpu_req && (state_q != CPU);
        gnt_eval = 1'b0;
        gnt_cpu  = 1'b0;
        if (!reset) begin
            if (eval_req && cpu_elig) begin
                if (line_active && (wait_q != WAIT_MAX)) begin
                    gnt_eval = 1'b1;
                end else begin
                    gnt_cpu = 1'b1;
                end
            end else if (eval_req) begin
                gnt_eval = 1'b1;
            end else if (cpu_elig) begin
                gnt_cpu = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = IDLE;
        wait_d     = wait_q;
        cpu_rd_d   = cpu_rd_q;
        mem_addr_d = mem_addr_q;
        mem_we     = 1'b0;
        mem_wdata  = cpu_wdata;

        if (gnt_eval) begin
            state_d    = EVAL;
            mem_addr_d = eval_addr;
        end else if (gnt_cpu) begin
            state_d    = CPU;
            mem_addr_d = cpu_addr;
            mem_we     = cpu_we;
            cpu_rd_d   = !cpu_we;
        end

        if (!cpu_req || gnt_cpu) begin
            wait_d = '0;
        end else if (cpu_elig && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end

        mem_addr   = mem_addr_d;
        eval_gnt   = gnt_eval;
        eval_valid = (state_q == EVAL);
        cpu_ack    = (state_q == CPU);
        eval_data  = eval_valid ? mem_rdata : 32'd0;
        cpu_rdata  = (cpu_ack && cpu_rd_q) ? mem_rdata : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            mem_addr_q <= '0;
            cpu_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            mem_addr_q <= mem_addr_d;
            cpu_rd_q   <= cpu_rd_d;
        end
    end

endmodule
